// File: rtl/laundry_pkg.sv
// Shared definitions for the laundromat controllers: clock-rate codes,
// arbiter state encoding and the seconds-timebase helper.
package laundry_pkg;

  // clk_freq codes; cycles per second is SEC_BASE << code
  localparam logic [1:0] FREQ_X1 = 2'b00;
  localparam logic [1:0] FREQ_X2 = 2'b01;
  localparam logic [1:0] FREQ_X4 = 2'b10;
  localparam logic [1:0] FREQ_X8 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Clock cycles in one second for a given base rate and frequency code
  function automatic int unsigned cycles_per_sec(input int unsigned sec_base,
                                                 input logic [1:0]  freq);
    return sec_base << freq;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds timebase: one-cycle tick every (SEC_BASE << freq_q) cycles while
// not held in clear. Shared with the wash timer.
module sec_tick_gen
  import laundry_pkg::*;
#(
  parameter int unsigned SEC_BASE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] freq_q,
  output logic       sec_tick_c
);

  localparam int unsigned CYC_W = $clog2(SEC_BASE * 8);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] last_c;

  // Cycle counter: wraps at the end of each second, saturates otherwise
  always_comb begin
    last_c     = CYC_W'(cycles_per_sec(SEC_BASE, freq_q) - 32'd1);
    sec_tick_c = 1'b0;
    cyc_d      = cyc_q;
    if (clear) begin
      cyc_d = '0;
    end else if (cyc_q == last_c) begin
      sec_tick_c = 1'b1;
      cyc_d      = '0;
    end else if (cyc_q != '1) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

endmodule

// File: rtl/drain_pump_arbiter.sv
// Round-robin owner selection for the shared drain/spin pump, with a
// seconds-based hold limit, timeout lockout and a pump-off gap between owners.
// `release` is a reserved word, so the early-release input is release_pulse.
module drain_pump_arbiter
  import laundry_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned SEC_BASE   = 1_000_000,
  parameter int unsigned HOLD_SEC   = 60,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 clk_freq,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           release_pulse,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned OWN_W = $clog2(N_REQ);
  localparam int unsigned SEC_W = $clog2(HOLD_SEC + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] lockout_q, lockout_d;
  logic [1:0]       freq_q, freq_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [N_REQ-1:0] elig_c;
  logic [OWN_W-1:0] pick_c;
  logic             end_norm_c;
  logic             tmo_c;
  logic             clear_c;
  logic             sec_tick_c;

  // First eligible index at or after ptr, wrapping around
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [OWN_W-1:0] ptr);
    logic [OWN_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!found && elig[OWN_W'(idx)]) begin
        pick  = OWN_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Seconds timebase runs only while a grant is active
  assign clear_c = (state_q != ST_GRANT);

  sec_tick_gen #(
    .SEC_BASE (SEC_BASE)
  ) u_sec_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_c),
    .freq_q     (freq_q),
    .sec_tick_c (sec_tick_c)
  );

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    freq_d     = freq_q;
    sec_d      = sec_q;
    gap_d      = gap_q;
    timeout_d  = 1'b0;
    lockout_d  = lockout_q & req;
    elig_c     = req & ~lockout_q;
    pick_c     = rr_pick(elig_c, ptr_q);
    end_norm_c = release_pulse[owner_q] || !req[owner_q];
    tmo_c      = sec_tick_c && (sec_q == SEC_W'(HOLD_SEC - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (|elig_c) begin
          grant_d = N_REQ'(1) << pick_c;
          owner_d = pick_c;
          freq_d  = clk_freq;
          sec_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (sec_tick_c && (sec_q != SEC_W'(HOLD_SEC))) sec_d = sec_q + SEC_W'(1);
        if (end_norm_c || tmo_c) begin
          grant_d = '0;
          ptr_d   = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
          gap_d   = '0;
          state_d = ST_GAP;
          // A normal end in the same cycle wins over the hold limit
          if (!end_norm_c) begin
            timeout_d          = 1'b1;
            lockout_d[owner_q] = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                  gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = |grant_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      lockout_q <= '0;
      freq_q    <= FREQ_X1;
      sec_q     <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      lockout_q <= lockout_d;
      freq_q    <= freq_d;
      sec_q     <= sec_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule
